// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer: start, LSB-first data, optional parity, stop
module uart_tx_serializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int Prescale_Width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [Prescale_Width-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_bit_q, par_bit_d;
    logic                      par_en_q, par_en_d;
    logic [Prescale_Width-1:0] presc_q, presc_d;
    logic [Prescale_Width-1:0] cnt_q, cnt_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      bit_done;

    assign bit_done = (cnt_q == (presc_q - Prescale_Width'(1)));

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        presc_d   = presc_q;
        cnt_d     = bit_done ? '0 : cnt_q + Prescale_Width'(1);
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (Data_Valid) begin
                    // Parity is resolved at acceptance so later input changes cannot leak in.
                    state_d   = START;
                    data_d    = P_DATA;
                    par_bit_d = (^P_DATA) ^ PAR_TYP;
                    par_en_d  = PAR_EN;
                    presc_d   = (Prescale == '0) ? Prescale_Width'(1) : Prescale;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    tx_d      = data_q[0];
                    data_d    = data_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        tx_d      = data_q[0];
                        data_d    = data_q >> 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            presc_q   <= Prescale_Width'(1);
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_serializer #(
        .DATA_WIDTH    (8),
        .Prescale_Width(6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, "_tx"}, TX_OUT, 1'b1);
            check({tag, "_busy"}, Busy, 1'b0);
        end
    endtask

    // Called at a negedge; returns at the negedge of the single idle cycle after the frame.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [5:0] p, input bit hold,
                             input bit disturb);
        logic exp_q[$];
        int   ones;
        int   plat;
        int   total;
        exp_q = {};
        ones  = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) exp_q.push_back(logic'((ones % 2) == 1) ^ pt);
        exp_q.push_back(1'b1);
        plat  = (p == 6'd0) ? 1 : int'(p);
        total = exp_q.size() * plat;

        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = p;
        Data_Valid = 1'b1;
        @(posedge clk);
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == 0) Data_Valid = hold;
            check({tag, "_tx"}, TX_OUT, exp_q[c / plat]);
            check({tag, "_busy"}, Busy, 1'b1);
            if (disturb && c == plat * 2) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'h3C;
                Prescale   = p + 6'd3;
                PAR_EN     = ~pe;
            end
            if (disturb && c == plat * 2 + 1) Data_Valid = 1'b0;
        end
        @(negedge clk);
        check({tag, "_gap_tx"}, TX_OUT, 1'b1);
        check({tag, "_gap_busy"}, Busy, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd1;
        repeat (2) @(negedge clk);
        check("reset_tx", TX_OUT, 1'b1);
        check("reset_busy", Busy, 1'b0);
        rst = 1'b0;
        check_idle("post_reset", 3);

        run_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
        check_idle("a5_nopar_idle", 2);
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0);
        check_idle("a5_even_idle", 2);
        run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 6'd8, 1'b0, 1'b0);
        check_idle("a5_odd_idle", 2);

        run_frame("disturb", 8'h96, 1'b1, 1'b0, 6'd5, 1'b0, 1'b1);
        check_idle("no_3c", 30);

        run_frame("b2b_1", 8'h5A, 1'b0, 1'b0, 6'd4, 1'b1, 1'b0);
        run_frame("b2b_2", 8'hC3, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0);
        check_idle("b2b_idle", 2);

        run_frame("ff_p1", 8'hFF, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0);
        check_idle("ff_p1_idle", 1);
        run_frame("ff_p0", 8'hFF, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        check_idle("ff_p0_idle", 1);

        P_DATA     = 8'h81;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd6;
        Data_Valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Data_Valid = 1'b0;
        repeat (13) @(negedge clk);
        check("midframe_busy", Busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", TX_OUT, 1'b1);
        check("abort_busy", Busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_idle("after_abort", 20);

        for (int k = 0; k < 10; k++) begin
            logic [7:0] rd;
            logic       rpe;
            logic       rpt;
            logic [5:0] rp;
            rd  = 8'($urandom);
            rpe = 1'($urandom_range(0, 1));
            rpt = 1'($urandom_range(0, 1));
            rp  = 6'($urandom_range(0, 5));
            run_frame("rand", rd, rpe, rpt, rp, bit'($urandom_range(0, 1)) && (k != 9), 1'b0);
        end
        Data_Valid = 1'b0;
        check_idle("final_idle", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
